// File: rtl/regfile_layer_seq.sv
// Layer sequencer for the activation/accumulator register file: clears the
// accumulators, runs every input activation through the MAC in 4-word groups, then drains.
module regfile_layer_seq #(
    parameter int IN_CNT_W = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                abort,
    input  logic [IN_CNT_W-1:0] num_in,
    input  logic [5:0]          num_out,
    input  logic                act_valid,
    output logic                act_ready,
    output logic                mac_start,
    input  logic                mac_done,
    output logic                wdata_sel,
    output logic                rst_syn,
    output logic                act_wen,
    output logic                acc_wen,
    output logic [3:0]          word_en,
    output logic [4:0]          acc_sel_w,
    output logic [4:0]          acc_sel_r,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_word_en,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_ACT,
        ISSUE,
        WAIT_MAC,
        DRAIN,
        DONE
    } state_t;

    localparam logic [IN_CNT_W-1:0] ONE_IN = {{(IN_CNT_W-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [IN_CNT_W-1:0] in_cnt, in_cnt_nxt, num_in_r;
    logic [5:0]          num_out_r, nout_m1;
    logic [2:0]          grp, grp_nxt, last_grp;
    logic [3:0]          grp_mask;
    logic                err_r, err_nxt;
    logic                start_bad, last_in;

    // Last group index is (num_out-1)/4, so bases never pass 28.
    assign nout_m1   = num_out_r - 6'd1;
    assign last_grp  = nout_m1[4:2];
    assign last_in   = (in_cnt == (num_in_r - ONE_IN));
    assign start_bad = (num_out == 6'd0) || (num_out > 6'd32);
    assign busy      = (state != IDLE);
    assign err       = err_r;

    always_comb begin
        grp_mask = 4'hf;
        if (grp == last_grp) begin
            case (num_out_r[1:0])
                2'd1:    grp_mask = 4'h1;
                2'd2:    grp_mask = 4'h3;
                2'd3:    grp_mask = 4'h7;
                default: grp_mask = 4'hf;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            in_cnt    <= '0;
            grp       <= '0;
            num_in_r  <= '0;
            num_out_r <= '0;
            err_r     <= 1'b0;
        end else begin
            state  <= state_nxt;
            in_cnt <= in_cnt_nxt;
            grp    <= grp_nxt;
            err_r  <= err_nxt;
            if (state == IDLE && start && !start_bad) begin
                num_in_r  <= num_in;
                num_out_r <= num_out;
            end
        end
    end

    // Write strobes and done are masked by abort so an aborted cycle leaves the regfile untouched.
    always_comb begin
        state_nxt   = state;
        in_cnt_nxt  = in_cnt;
        grp_nxt     = grp;
        err_nxt     = 1'b0;
        act_ready   = 1'b0;
        mac_start   = 1'b0;
        wdata_sel   = 1'b0;
        rst_syn     = 1'b0;
        act_wen     = 1'b0;
        acc_wen     = 1'b0;
        word_en     = 4'h0;
        acc_sel_w   = 5'd0;
        acc_sel_r   = 5'd0;
        out_valid   = 1'b0;
        out_word_en = 4'h0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (start_bad) err_nxt = 1'b1;
                    else           state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                rst_syn    = ~abort;
                in_cnt_nxt = '0;
                grp_nxt    = '0;
                state_nxt  = (num_in_r == '0) ? DRAIN : LOAD_ACT;
            end
            LOAD_ACT: begin
                act_ready = 1'b1;
                act_wen   = act_valid & ~abort;
                if (act_valid) begin
                    grp_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                acc_sel_r = {grp, 2'b00};
                mac_start = 1'b1;
                state_nxt = WAIT_MAC;
            end
            WAIT_MAC: begin
                acc_sel_r = {grp, 2'b00};
                acc_sel_w = {grp, 2'b00};
                wdata_sel = 1'b1;
                word_en   = grp_mask;
                if (mac_done) begin
                    acc_wen = ~abort;
                    if (grp != last_grp) begin
                        grp_nxt   = grp + 3'd1;
                        state_nxt = ISSUE;
                    end else if (last_in) begin
                        grp_nxt   = '0;
                        state_nxt = DRAIN;
                    end else begin
                        in_cnt_nxt = in_cnt + ONE_IN;
                        state_nxt  = LOAD_ACT;
                    end
                end
            end
            DRAIN: begin
                out_valid   = 1'b1;
                acc_sel_r   = {grp, 2'b00};
                out_word_en = grp_mask;
                if (out_ready) begin
                    if (grp == last_grp) state_nxt = DONE;
                    else                 grp_nxt   = grp + 3'd1;
                end
            end
            DONE: begin
                done      = ~abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE && abort) state_nxt = IDLE;
    end

endmodule

// File: tb/tb_regfile_layer_seq.sv
// Self-checking bench for regfile_layer_seq: table of layer shapes scored against
// queues of expected accumulator writes and drain groups, plus abort/reset sequences.
module tb_regfile_layer_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_in = '0;
    logic [5:0]  num_out = '0;
    logic        act_valid = 1'b0;
    logic        act_ready;
    logic        mac_start;
    logic        mac_done = 1'b0;
    logic        wdata_sel;
    logic        rst_syn;
    logic        act_wen;
    logic        acc_wen;
    logic [3:0]  word_en;
    logic [4:0]  acc_sel_w;
    logic [4:0]  acc_sel_r;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_word_en;
    logic        busy;
    logic        done;
    logic        err;

    regfile_layer_seq #(.IN_CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .num_in(num_in), .num_out(num_out),
        .act_valid(act_valid), .act_ready(act_ready),
        .mac_start(mac_start), .mac_done(mac_done),
        .wdata_sel(wdata_sel), .rst_syn(rst_syn),
        .act_wen(act_wen), .acc_wen(acc_wen), .word_en(word_en),
        .acc_sel_w(acc_sel_w), .acc_sel_r(acc_sel_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_word_en(out_word_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         nin;
        int         nout;
        int         lat;
        bit         stall;
        int         exp_err;
        int         exp_grps;
        int         exp_wen;
        logic [3:0] exp_last;
    } vec_t;

    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;
    logic [8:0] acc_q[$];
    logic [8:0] drain_q[$];

    function automatic logic [3:0] model_mask(input int nout, input int g);
        int ng;
        ng = (nout + 3) / 4;
        if (g != ng - 1) return 4'hf;
        case (nout % 4)
            1:       return 4'h1;
            2:       return 4'h3;
            3:       return 4'h7;
            default: return 4'hf;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one layer; expected writes are queued as each activation is accepted.
    task automatic applyStimulus(input vec_t v, input int idx);
        int         pend, k, ng;
        int         err_cnt, rst_cnt, act_cnt, wen_cnt, drains, done_cnt, busy_cnt, rdy_cnt;
        bit         fin, prev_stall;
        logic [4:0] prev_sel, last_sel;
        logic [3:0] prev_mask, last_mask;
        logic [3:0] pat;
        logic [8:0] exp_item;
        string      tag;

        pend = 0; k = 0; fin = 0; prev_stall = 0;
        err_cnt = 0; rst_cnt = 0; act_cnt = 0; wen_cnt = 0;
        drains = 0; done_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
        prev_sel = '0; prev_mask = '0; last_sel = '0; last_mask = '0;
        pat = 4'b1001;
        ng = (v.nout + 3) / 4;
        tag = $sformatf("v%0d", idx);
        acc_q.delete();
        drain_q.delete();

        @(posedge CLK); #1;
        start = 1'b1; num_in = 16'(v.nin); num_out = 6'(v.nout);
        act_valid = 1'b1; out_ready = 1'b1; mac_done = 1'b0; abort = 1'b0;
        if (v.exp_err == 0)
            for (int g = 0; g < ng; g++) drain_q.push_back({5'(4 * g), model_mask(v.nout, g)});
        @(negedge CLK);

        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(posedge CLK); #1;
            start    = 1'b0;
            num_in   = 16'($urandom);
            num_out  = 6'($urandom);
            mac_done = (pend == 1);
            if (pend > 0) pend--;
            out_ready = v.stall ? pat[k % 4] : 1'b1;
            k++;
            @(negedge CLK);

            if (busy)      busy_cnt++;
            if (act_ready) rdy_cnt++;
            if (rst_syn)   rst_cnt++;
            if (err)       err_cnt++;
            if (act_wen) begin
                act_cnt++;
                for (int g = 0; g < ng; g++) acc_q.push_back({5'(4 * g), model_mask(v.nout, g)});
            end
            if (acc_wen) begin
                wen_cnt++;
                last_sel = acc_sel_w;
                checkOutput({tag, " wdata_sel"}, wdata_sel, 1);
                if (acc_q.size() == 0) checkOutput({tag, " unexpected acc_wen"}, 1, 0);
                else begin
                    exp_item = acc_q.pop_front();
                    checkOutput({tag, " acc write"}, {acc_sel_w, word_en}, exp_item);
                end
            end
            if (out_valid) begin
                if (prev_stall)
                    checkOutput({tag, " drain stable"}, {acc_sel_r, out_word_en}, {prev_sel, prev_mask});
                if (out_ready) begin
                    drains++;
                    last_mask = out_word_en;
                    if (drain_q.size() == 0) checkOutput({tag, " unexpected drain"}, 1, 0);
                    else begin
                        exp_item = drain_q.pop_front();
                        checkOutput({tag, " drain group"}, {acc_sel_r, out_word_en}, exp_item);
                    end
                end
                prev_stall = !out_ready;
                prev_sel   = acc_sel_r;
                prev_mask  = out_word_en;
            end else begin
                prev_stall = 0;
            end
            if (mac_start) pend = v.lat;
            if (done) begin
                done_cnt++;
                fin = 1;
            end
            if (v.exp_err != 0 && cyc >= 4) fin = 1;
        end

        if (v.exp_err == 0) checkOutput({tag, " timeout"}, done_cnt, 1);
        else begin
            checkOutput({tag, " done"}, done_cnt, 0);
            checkOutput({tag, " busy"}, busy_cnt, 0);
        end
        checkOutput({tag, " err count"}, err_cnt, v.exp_err);
        checkOutput({tag, " rst_syn count"}, rst_cnt, (v.exp_err == 0) ? 1 : 0);
        checkOutput({tag, " act_wen count"}, act_cnt, (v.exp_err == 0) ? v.nin : 0);
        checkOutput({tag, " acc_wen count"}, wen_cnt, v.exp_wen);
        checkOutput({tag, " drain count"}, drains, v.exp_grps);
        checkOutput({tag, " acc queue left"}, acc_q.size(), 0);
        checkOutput({tag, " drain queue left"}, drain_q.size(), 0);
        if (v.exp_grps > 0) checkOutput({tag, " last drain mask"}, last_mask, v.exp_last);
        if (v.exp_wen > 0)  checkOutput({tag, " last acc_sel_w"}, last_sel, 4 * (v.exp_grps - 1));
        if (v.nin == 0)     checkOutput({tag, " act_ready seen"}, rdy_cnt, 0);
    endtask

    initial begin
        bit found;

        //            nin nout lat stall err grps wen last
        vecs[0] = '{1,  4,  3, 1'b0, 0, 1, 1,  4'hf};
        vecs[1] = '{3,  10, 3, 1'b0, 0, 3, 9,  4'h3};
        vecs[2] = '{2,  32, 2, 1'b1, 0, 8, 16, 4'hf};
        vecs[3] = '{0,  0,  3, 1'b0, 1, 0, 0,  4'h0};
        vecs[4] = '{2,  33, 3, 1'b0, 1, 0, 0,  4'h0};
        vecs[5] = '{0,  5,  3, 1'b0, 0, 2, 0,  4'h1};
        vecs[6] = '{2,  7,  1, 1'b0, 0, 2, 4,  4'h7};
        vecs[7] = '{1,  1,  5, 1'b1, 0, 1, 1,  4'h1};

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkOutput("reset strobes",
                    {busy, done, err, out_valid, act_ready, mac_start, rst_syn, acc_wen, act_wen, wdata_sel}, 0);
        checkOutput("reset word_en", word_en, 0);
        checkOutput("reset acc_sel", {acc_sel_w, acc_sel_r}, 0);
        checkOutput("reset out_word_en", out_word_en, 0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // abort coinciding with mac_done: no write, no done, back to IDLE
        @(posedge CLK); #1;
        start = 1'b1; num_in = 16'd1; num_out = 6'd4; act_valid = 1'b1; out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge CLK); #1;
            start = 1'b0;
            @(negedge CLK);
            if (mac_start) found = 1;
        end
        checkOutput("abort reach issue", found, 1);
        @(posedge CLK); #1;
        abort = 1'b1; mac_done = 1'b1;
        @(negedge CLK);
        checkOutput("abort in wait_mac", wdata_sel, 1);
        checkOutput("abort acc_wen", acc_wen, 0);
        checkOutput("abort done", done, 0);
        @(posedge CLK); #1;
        abort = 1'b0; mac_done = 1'b0;
        @(negedge CLK);
        checkOutput("abort idle busy", busy, 0);
        checkOutput("abort idle done", done, 0);

        // asynchronous reset while a drain is stalled
        @(posedge CLK); #1;
        start = 1'b1; num_in = 16'd0; num_out = 6'd32; out_ready = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge CLK); #1;
            start = 1'b0;
            @(negedge CLK);
            if (out_valid) found = 1;
        end
        checkOutput("rst reach drain", found, 1);
        #2 RST = 1'b1;
        #1;
        checkOutput("rst drain outputs", {out_valid, busy, out_word_en, acc_sel_r}, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst released idle", {busy, done, rst_syn}, 0);

        applyStimulus(vecs[1], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
